// File: rtl/tetris_pkg.sv
// Shared piece encoding, bag mask type and small helpers for the piece randomizer.
package tetris_pkg;

    typedef enum logic [2:0] {
        I = 3'd0,
        O = 3'd1,
        T = 3'd2,
        S = 3'd3,
        Z = 3'd4,
        J = 3'd5,
        L = 3'd6
    } piece_t;

    localparam int NUM_PIECES = 7;

    typedef logic [NUM_PIECES-1:0] bag_t;

    localparam bag_t BAG_FULL = '1;

    function automatic bag_t piece_onehot(input logic [2:0] p);
        bag_t m;
        m = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if (p == i[2:0]) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Lowest-index piece not yet dealt in the current bag.
    function automatic piece_t lowest_free(input bag_t bag);
        piece_t p;
        p = I;
        for (int i = NUM_PIECES - 1; i >= 0; i--) begin
            if (!bag[i]) begin
                p = piece_t'(i[2:0]);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/piece_randomizer_if.sv
// Consumer-side handshake of the piece randomizer: head/preview pieces and pop.
interface piece_randomizer_if;
    import tetris_pkg::*;

    logic   pop;
    logic   piece_valid;
    piece_t piece;
    logic   preview_valid;
    piece_t preview;

    // master: the randomizer producing pieces; slave: the game FSM consuming them
    modport master (
        input  pop,
        output piece_valid,
        output piece,
        output preview_valid,
        output preview
    );

    modport slave (
        output pop,
        input  piece_valid,
        input  piece,
        input  preview_valid,
        input  preview
    );

endinterface

// File: rtl/piece_randomizer_queue.sv
// Small shift-style FIFO of pieces; slot 0 is the head, unused slots are kept at zero.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         push,
    input  logic                         pop,
    input  piece_t                       din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output piece_t                       head,
    output piece_t                       next
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    piece_t        ent_q [DEPTH];
    piece_t        ent_d [DEPTH];
    logic          pop_ok;
    logic          push_ok;
    int            wr_idx;

    assign pop_ok  = pop && (cnt_q != '0);
    assign push_ok = push && ((cnt_q != DEPTH_C) || pop_ok);
    assign wr_idx  = pop_ok ? (int'(cnt_q) - 1) : int'(cnt_q);

    always_comb begin
        ent_d = ent_q;
        cnt_d = cnt_q;
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
            ent_d[DEPTH-1] = I;
        end
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == wr_idx) begin
                    ent_d[i] = din;
                end
            end
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= I;
            end
        end else begin
            cnt_q <= cnt_d;
            ent_q <= ent_d;
        end
    end

    assign count = cnt_q;
    assign head  = ent_q[0];
    assign next  = ent_q[1];

endmodule

// File: rtl/piece_randomizer.sv
// Turns the serial LFSR bit stream into a 7-bag-fair tetromino sequence with a short preview queue.
module piece_randomizer
    import tetris_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int MAX_REJECTS = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              rand_bit,
    piece_randomizer_if.master q_if
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
    localparam int RW = (MAX_REJECTS > 1) ? $clog2(MAX_REJECTS) : 1;
    localparam logic [RW-1:0] REJ_LAST = RW'(MAX_REJECTS - 1);

    logic [1:0]    cnt_q, cnt_d;
    logic [1:0]    sr_q, sr_d;
    bag_t          bag_q, bag_d;
    logic [RW-1:0] rej_q, rej_d;

    logic [2:0]    cand;
    logic          cand_cycle;
    logic          pop_eff;
    logic          room;
    logic          rejected;
    logic [7:0]    bag_ext;
    logic          push;
    piece_t        push_piece;
    bag_t          bag_next;

    logic [CW-1:0] q_count;
    piece_t        q_head;
    piece_t        q_next;

    assign cand       = {sr_q, rand_bit};
    assign cand_cycle = (cnt_q == 2'd2);
    assign pop_eff    = q_if.pop && q_if.piece_valid;
    assign room       = (q_count != DEPTH_C) || pop_eff;
    // Bit 7 stands in for the unused code 7 so one lookup covers both reject causes.
    assign bag_ext    = {1'b1, bag_q};
    assign rejected   = bag_ext[cand];

    always_comb begin
        cnt_d      = cand_cycle ? 2'd0 : (cnt_q + 2'd1);
        sr_d       = {sr_q[0], rand_bit};
        bag_d      = bag_q;
        rej_d      = rej_q;
        push       = 1'b0;
        push_piece = I;
        bag_next   = '0;
        if (cand_cycle && room) begin
            if (!rejected) begin
                push       = 1'b1;
                push_piece = piece_t'(cand);
            end else if (rej_q == REJ_LAST) begin
                push       = 1'b1;
                push_piece = lowest_free(bag_q);
            end
            if (push) begin
                bag_next = bag_q | piece_onehot(push_piece);
                bag_d    = (bag_next == BAG_FULL) ? '0 : bag_next;
                rej_d    = '0;
            end else begin
                rej_d = rej_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= 2'd0;
            sr_q  <= 2'd0;
            bag_q <= '0;
            rej_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
            bag_q <= bag_d;
            rej_q <= rej_d;
        end
    end

    piece_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .pop    (pop_eff),
        .din    (push_piece),
        .count  (q_count),
        .head   (q_head),
        .next   (q_next)
    );

    assign q_if.piece_valid   = (q_count != '0);
    assign q_if.preview_valid = (q_count > CW'(1));
    assign q_if.piece         = q_head;
    assign q_if.preview       = q_next;

endmodule

// File: tb/tb_piece_randomizer.sv
// Vector-table bench for piece_randomizer with a scoreboard of expected queue contents.
module tb_piece_randomizer;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic rand_bit = 1'b0;

    piece_randomizer_if ifc ();

    piece_randomizer #(
        .QUEUE_DEPTH (2),
        .MAX_REJECTS (8)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .rand_bit (rand_bit),
        .q_if     (ifc.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int cand;
        bit pop;
        bit push;
        int piece;
        int bag;
        int rej;
    } vec_t;

    vec_t vecs[$];
    int   sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit rst, input int cand, input bit pop, input bit push,
                       input int piece, input int bag, input int rej);
        vec_t v;
        v.rst = rst; v.cand = cand; v.pop = pop; v.push = push;
        v.piece = piece; v.bag = bag; v.rej = rej;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag);
        int n;
        n = sb.size();
        chk({tag, "_piece_valid"}, int'(ifc.piece_valid), (n > 0) ? 1 : 0);
        chk({tag, "_piece"}, int'(ifc.piece), (n > 0) ? sb[0] : 0);
        chk({tag, "_preview_valid"}, int'(ifc.preview_valid), (n > 1) ? 1 : 0);
        chk({tag, "_preview"}, int'(ifc.preview), (n > 1) ? sb[1] : 0);
    endtask

    task automatic do_reset(input string tag);
        nreset = 1'b0;
        ifc.pop = 1'b0;
        rand_bit = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check_outputs(tag);
        chk({tag, "_bag"}, int'(dut.bag_q), 0);
        chk({tag, "_rej"}, int'(dut.rej_q), 0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [2:0] b;
        string tag;
        b = v.cand[2:0];
        tag = $sformatf("v%0d", idx);
        if (v.rst) do_reset({tag, "_rst"});
        for (int i = 2; i >= 0; i--) begin
            rand_bit = b[i];
            ifc.pop = (i == 0) && v.pop;
            if (i == 0 && v.pop && sb.size() > 0) begin
                chk({tag, "_pop_head"}, int'(ifc.piece), sb[0]);
                void'(sb.pop_front());
            end
            @(posedge clk);
            #1;
            if (i != 0) chk({tag, "_pre_valid"}, int'(ifc.piece_valid), (sb.size() > 0) ? 1 : 0);
        end
        ifc.pop = 1'b0;
        if (v.push) sb.push_back(v.piece);
        check_outputs(tag);
        chk({tag, "_bag"}, int'(dut.bag_q), v.bag);
        chk({tag, "_rej"}, int'(dut.rej_q), v.rej);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.pop = 1'b0;
        // rst cand pop push piece bag rej
        add(1, 2, 0, 1, 2, 'h04, 0);           // first piece T
        add(1, 7, 1, 0, 0, 'h00, 1);           // 7 rejected; pop on empty ignored
        add(0, 1, 0, 1, 1, 'h02, 0);
        add(1, 2, 0, 1, 2, 'h04, 0);           // bag hit on second 2
        add(0, 2, 0, 0, 0, 'h04, 1);
        add(0, 5, 0, 1, 5, 'h24, 0);
        add(1, 0, 0, 1, 0, 'h01, 0);           // full bag 0..6
        add(0, 1, 0, 1, 1, 'h03, 0);
        add(0, 2, 1, 1, 2, 'h07, 0);
        add(0, 3, 1, 1, 3, 'h0F, 0);
        add(0, 4, 1, 1, 4, 'h1F, 0);
        add(0, 5, 1, 1, 5, 'h3F, 0);
        add(0, 6, 1, 1, 6, 'h00, 0);
        add(0, 0, 1, 1, 0, 'h01, 0);
        add(1, 1, 0, 1, 1, 'h02, 0);           // build bag 7'b1111110
        add(0, 2, 0, 1, 2, 'h06, 0);
        add(0, 3, 1, 1, 3, 'h0E, 0);
        add(0, 4, 1, 1, 4, 'h1E, 0);
        add(0, 5, 1, 1, 5, 'h3E, 0);
        add(0, 6, 1, 1, 6, 'h7E, 0);
        add(0, 7, 1, 0, 0, 'h7E, 1);
        for (int k = 2; k <= 7; k++) add(0, 7, 0, 0, 0, 'h7E, k);
        add(0, 7, 0, 1, 0, 'h00, 0);           // fallback deals I
        add(1, 0, 0, 1, 0, 'h01, 0);           // full-queue behaviour
        add(0, 1, 0, 1, 1, 'h03, 0);
        add(0, 2, 0, 0, 0, 'h03, 0);
        add(0, 7, 0, 0, 0, 'h03, 0);
        add(0, 4, 1, 1, 4, 'h13, 0);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // asynchronous reset mid-cycle, then recovery
        rand_bit = 1'b1;
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        sb.delete();
        check_outputs("async_rst");
        chk("async_rst_bag", int'(dut.bag_q), 0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        begin
            vec_t v;
            v.rst = 0; v.cand = 3; v.pop = 0; v.push = 1; v.piece = 3; v.bag = 'h08; v.rej = 0;
            run_vec(100, v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
